// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with loadable pattern,
// overlap/non-overlap modes and a saturating match counter.
//
// Ports:
//   clk, rst      rising-edge clock, async active-high reset
//   en, din       din is sampled only when en=1
//   overlap       1: overlapping detection, 0: non-overlapping
//   load, pat_in  load strobe and new pattern value
//   cnt_clr       synchronous clear of match_cnt
//   dout          Mealy match flag (combinational)
//   match_cnt     registered saturating count of matches
module seq_detector_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1011,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = (N > 2) ? $clog2(N) : 1;
  localparam logic [FW-1:0] LAST = FW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]  pat;
  logic [N-2:0]  hist;
  logic [FW-1:0] fill;

  logic          accept;
  logic          hit;
  logic [N-1:0]  win;

  // Window of the last N bits including the current one.
  assign win    = {hist, din};
  assign accept = en & ~load;
  assign hit    = accept & (fill == LAST) & (win == pat);
  assign dout   = hit & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else if (load) begin
      pat  <= pat_in;
      fill <= '0;
    end else if (en) begin
      hist <= win[N-2:0];
      if (hit) begin
        // Non-overlap mode restarts the fill; history is then stale
        // but unused until N fresh bits have arrived.
        fill <= overlap ? LAST : '0;
      end else if (fill != LAST) begin
        fill <= fill + FW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_cnt <= '0;
    end else if (cnt_clr) begin
      match_cnt <= '0;
    end else if (dout && match_cnt != CNT_MAX) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vectors, literal checks,
// and a queue-based reference model compared every cycle.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       overlap = 1'b1;
  logic       load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       cnt_clr = 1'b0;
  logic       dout;
  logic [7:0] match_cnt;

  logic       b_en = 1'b0;
  logic       b_din = 1'b0;
  logic       b_clr = 1'b0;
  logic       b_ov = 1'b1;
  logic       b_load = 1'b0;
  logic [3:0] b_pat = 4'b0000;
  logic       b_dout;
  logic [1:0] b_cnt;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .rst(rst), .en(en), .din(din),
    .overlap(overlap), .load(load), .pat_in(pat_in),
    .cnt_clr(cnt_clr), .dout(dout), .match_cnt(match_cnt)
  );

  seq_detector_param #(
    .N(4), .PATTERN(4'b1111), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .din(b_din),
    .overlap(b_ov), .load(b_load), .pat_in(b_pat),
    .cnt_clr(b_clr), .dout(b_dout), .match_cnt(b_cnt)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the accepted bits since the last restart,
  // oldest first, at most N-1 of them retained.
  bit         mq[$];
  logic [3:0] mpat = 4'b1011;
  int         mcnt = 0;
  logic       mexp;

  function automatic logic model_hit();
    logic [3:0] w;
    if (rst || !en || load || mq.size() != 3) return 1'b0;
    w = {mq[0], mq[1], mq[2], din};
    return w == mpat;
  endfunction

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        mpat = 4'b1011;
        mcnt = 0;
      end
      mexp = model_hit();
      chk("model_dout", {31'd0, dout}, {31'd0, mexp});
      chk("model_cnt", {24'd0, match_cnt}, mcnt);
      @(posedge clk);
      if (!rst) begin
        if (cnt_clr) mcnt = 0;
        else if (mexp && mcnt < 255) mcnt++;
        if (load) begin
          mpat = pat_in;
          mq.delete();
        end else if (en) begin
          if (mexp && !overlap) begin
            mq.delete();
          end else begin
            mq.push_back(din);
            if (mq.size() > 3) void'(mq.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input logic e, input logic d,
                      input logic ld, input logic [3:0] pi,
                      input logic clr);
    @(posedge clk);
    #1;
    en = e; din = d; load = ld; pat_in = pi; cnt_clr = clr;
    @(negedge clk);
    #1;
  endtask

  task automatic run7(input logic [6:0] bits,
                      input logic [6:0] exp,
                      input string name);
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 4'($urandom), 1'b0);
      chk(name, {31'd0, dout}, {31'd0, exp[i]});
    end
  endtask

  task automatic bstep(input logic d, input logic clr);
    @(posedge clk);
    #1;
    b_en = 1'b1; b_din = d; b_clr = clr;
    @(negedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    @(negedge clk);
    #1;
    chk("rst_dout", {31'd0, dout}, 32'd0);
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    overlap = 1'b1;
    run7(7'b1011011, 7'b0001001, "ovl_1011");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("ovl_cnt", {24'd0, match_cnt}, 32'd2);

    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    overlap = 1'b0;
    run7(7'b1011011, 7'b0001000, "novl_1011");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("novl_cnt", {24'd0, match_cnt}, 32'd1);

    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'b1101, 1'b1);
    chk("load_dout", {31'd0, dout}, 32'd0);
    run7(7'b1101101, 7'b0001001, "load_1101");
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("load_cnt", {24'd0, match_cnt}, 32'd2);

    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b1);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'(i == 1 ? 0 : 1), 1'b0, 4'b0000, 1'b0);
      chk("en_low", {31'd0, dout}, 32'd0);
    end
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("en_resume", {31'd0, dout}, 32'd1);

    step(1'b0, 1'b0, 1'b1, 4'b1011, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    chk("pre_rst_cnt", {24'd0, match_cnt}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b1; din = 1'b1;
    @(negedge clk);
    #1;
    chk("in_rst_dout", {31'd0, dout}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_dout", {31'd0, dout}, 32'd0);
    chk("post_rst_cnt", {24'd0, match_cnt}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    for (int i = 1; i <= 8; i++) begin
      bstep(1'b1, 1'b0);
      chk("b_dout", {31'd0, b_dout}, {31'd0, 1'(i >= 4)});
      chk("b_cnt", {30'd0, b_cnt}, (i <= 4) ? 0 : ((i - 4 > 3) ? 3 : i - 4));
    end
    bstep(1'b1, 1'b1);
    chk("b_sat", {30'd0, b_cnt}, 32'd3);
    chk("b_clr_dout", {31'd0, b_dout}, 32'd1);
    @(posedge clk);
    #1;
    b_en = 1'b0; b_clr = 1'b0;
    @(negedge clk);
    #1;
    chk("b_clr_cnt", {30'd0, b_cnt}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 Parameter N, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PATTERN, default 4'b1011 (width N): pattern loaded at reset; MSB is the first bit expected.
REQ-003 Parameter CNT_W, default 8: match-counter width, legal range 1..32.
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 en  input  1  din valid qualifier; din is sampled only when en=1.
REQ-007 din  input  1  serial data bit.
REQ-008 overlap  input  1  mode select: 1=overlapping detection, 0=non-overlapping detection; sampled each cycle.
REQ-009 load  input  1  pattern load strobe.
REQ-010 pat_in  input  N  new pattern, captured when load=1.
REQ-011 cnt_clr  input  1  synchronous clear of match_cnt.
REQ-012 dout  output  1  Mealy match flag, combinational from state and current inputs.
REQ-013 match_cnt  output  CNT_W  registered saturating count of matches.

Function
REQ-014 Block SHALL hold a pattern register pat[N-1:0], a history register hist[N-2:0] (most recent bit in hist[0]) and a fill counter fill (0..N-1).
REQ-015 Accepted bit: en=1 and load=0 in the same cycle.
REQ-016 dout SHALL be 1 iff accepted bit, fill==N-1, and {hist[N-2:0],din}==pat; dout SHALL be 0 otherwise, including whenever en=0 or load=1.
REQ-017 On an accepted bit with no match, hist SHALL shift left with din entering hist[0], and fill SHALL increment, saturating at N-1.
REQ-018 On a match with overlap=1, hist SHALL shift as in REQ-017 and fill SHALL stay N-1, so the pattern suffix can start the next match.
REQ-019 On a match with overlap=0, fill SHALL go to 0; hist contents become don't-care; the next match needs N further accepted bits.
REQ-020 If en=0 and load=0, hist, fill and pat SHALL hold.
REQ-021 load=1 SHALL write pat<=pat_in and fill<=0 at the clock edge, regardless of en; bits presented in the load cycle are discarded.
REQ-022 match_cnt SHALL increment by 1 on every edge where dout=1, and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-023 cnt_clr=1 SHALL set match_cnt to 0 at the edge, with priority over a simultaneous increment.
REQ-024 Detection latency: dout SHALL assert in the same cycle as the final pattern bit; match_cnt SHALL reflect that match one edge later.
REQ-025 Self-overlapping patterns (e.g. 1111, 1010) SHALL be detected at every qualifying position when overlap=1.
REQ-026 With N=4, PATTERN=1011, overlap=1, and load/cnt_clr never asserted, dout SHALL match a 4-state overlapping Mealy 1011 detector bit-for-bit.

Reset
REQ-027 rst=1 SHALL set, asynchronously, pat<=PATTERN, hist<=0, fill<=0 and match_cnt<=0.
REQ-028 While rst=1, dout SHALL be 0.
REQ-029 Reset mid-sequence SHALL discard partial history: no match can complete until N bits have been accepted after rst deasserts.

Verification
REQ-030 Defaults, overlap=1, en=1, din=1,0,1,1,0,1,1 -> dout=1 on bits 4 and 7 only; match_cnt=2 after the final edge.
REQ-031 Same stream with overlap=0 -> dout=1 on bit 4 only; match_cnt=1.
REQ-032 load=1 with pat_in=4'b1101 for one cycle, then din=1,1,0,1,1,0,1 with overlap=1 -> dout=1 on bits 4 and 7; pat_in ignored while load=0.
REQ-033 din=1,0,1 with en=1, then en=0 for 3 cycles with din toggling, then en=1 with din=1 -> dout=1 on that final bit; no dout while en=0.
REQ-034 din=1,0,1, then rst pulse, then din=1 -> dout=0; match_cnt=0.
REQ-035 CNT_W=2, pattern 1111, overlap=1, 8 ones -> dout on bits 4..8; match_cnt saturates at 3; cnt_clr together with a match -> match_cnt=0.
